// File: rtl/ublock_pkg.sv
// ---------------------------------------------------------------------------
// ublock_pkg
// Shared definitions for the uBlock round-constant logic. The encryption
// LFSR walks RC_FIRST_ENC -> ... -> RC_LAST_ENC; the decryption controller
// walks the same chain in reverse.
//
// Contents:
//   RC_FIRST_ENC   constant used by encryption round 0
//   RC_SECOND_ENC  constant used by encryption round 1
//   RC_LAST_ENC    constant used by the final encryption round
//   rc_state_e     controller states {IDLE, RUN, DONE}
//   rc_inv_step()  one backwards step of the round-constant LFSR
// ---------------------------------------------------------------------------
package ublock_pkg;

    localparam logic [7:0] RC_FIRST_ENC  = 8'h36;
    localparam logic [7:0] RC_SECOND_ENC = 8'h1B;
    localparam logic [7:0] RC_LAST_ENC   = 8'h87;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } rc_state_e;

    // The forward step shifts right and feeds r0^r1^r5^r6 into bit 7.
    // Going backwards, the old r[7:1] is the new n[6:0], and the old r0 is
    // recovered by cancelling the other three taps out of n[7].
    function automatic logic [7:0] rc_inv_step(input logic [7:0] n);
        return {n[6:0], n[7] ^ n[0] ^ n[4] ^ n[5]};
    endfunction

endpackage : ublock_pkg

// File: rtl/lfsr_inv_step.sv
// ---------------------------------------------------------------------------
// lfsr_inv_step
// Pure combinational inverse step of the 8-bit uBlock round-constant LFSR.
// Kept as its own block so the key-schedule inversion can share it.
//
// Ports:
//   rc_in   [7:0]  current constant
//   rc_out  [7:0]  constant of the previous encryption round
// ---------------------------------------------------------------------------
module lfsr_inv_step
    import ublock_pkg::*;
(
    input  logic [7:0] rc_in,
    output logic [7:0] rc_out
);

    assign rc_out = rc_inv_step(rc_in);

endmodule : lfsr_inv_step

// File: rtl/lfsr_inv_ctrl.sv
// ---------------------------------------------------------------------------
// lfsr_inv_ctrl
// Decryption-side round-constant controller. On start it presents START_RC,
// then steps the LFSR backwards once per rc_ready handshake until END_RC has
// been consumed. A watchdog aborts the run with an err pulse if END_RC is
// never reached within MAX_STEPS accepted rounds.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a run (only acted on in IDLE)
//   abort        return to IDLE from any state, no done/err
//   rc_ready     datapath consumed rc; advance
//   rc           current round constant (registered)
//   rc_valid     rc is valid for the datapath (RUN)
//   first_round  rc is the first decryption constant
//   last_round   rc is END_RC or the second encryption constant
//   round_cnt    inverse steps taken in the current run
//   busy         high in RUN
//   done         one-cycle pulse after END_RC was consumed
//   err          one-cycle pulse on watchdog expiry
// ---------------------------------------------------------------------------
module lfsr_inv_ctrl
    import ublock_pkg::*;
#(
    parameter logic [7:0]  START_RC  = RC_LAST_ENC,
    parameter logic [7:0]  END_RC    = RC_FIRST_ENC,
    parameter int unsigned MAX_STEPS = 255,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             rc_ready,
    output logic [7:0]       rc,
    output logic             rc_valid,
    output logic             first_round,
    output logic             last_round,
    output logic [CNT_W-1:0] round_cnt,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // The accept that happens while round_cnt sits here is the last one the
    // watchdog allows; it fires instead of stepping, so the counter never wraps.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_STEPS - 1);

    rc_state_e        state_q, state_d;
    logic [7:0]       rc_q, rc_d;
    logic [CNT_W-1:0] round_cnt_q, round_cnt_d;
    logic             err_q, err_d;
    logic [7:0]       rc_prev;

    lfsr_inv_step u_step (
        .rc_in  (rc_q),
        .rc_out (rc_prev)
    );

    // State register. Reset reloads the starting constant so rc is already
    // correct when the first run begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rc_q        <= START_RC;
            round_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rc_q        <= rc_d;
            round_cnt_q <= round_cnt_d;
            err_q       <= err_d;
        end
    end

    // Next-state logic. abort overrides everything; round_cnt keeps the
    // last run's count until the next start clears it.
    always_comb begin
        state_d     = state_q;
        rc_d        = rc_q;
        round_cnt_d = round_cnt_q;
        err_d       = 1'b0;

        if (abort) begin
            state_d = IDLE;
            rc_d    = START_RC;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d     = RUN;
                        rc_d        = START_RC;
                        round_cnt_d = '0;
                    end
                end
                RUN: begin
                    if (rc_ready) begin
                        if (rc_q == END_RC) begin
                            state_d = DONE;
                        end else if (round_cnt_q == LAST_CNT) begin
                            state_d = IDLE;
                            rc_d    = START_RC;
                            err_d   = 1'b1;
                        end else begin
                            rc_d        = rc_prev;
                            round_cnt_d = round_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                    rc_d    = START_RC;
                end
                default: begin
                    state_d = IDLE;
                    rc_d    = START_RC;
                end
            endcase
        end
    end

    // Outputs decode purely from registered state, so no input reaches rc
    // or the status flags combinationally.
    assign rc          = rc_q;
    assign round_cnt   = round_cnt_q;
    assign busy        = (state_q == RUN);
    assign rc_valid    = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign err         = err_q;
    assign first_round = (state_q == RUN) && (rc_q == START_RC);
    assign last_round  = (state_q == RUN) &&
                         ((rc_q == END_RC) || (rc_q == RC_SECOND_ENC));

endmodule : lfsr_inv_ctrl

// File: tb/tb_lfsr_inv_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lfsr_inv_ctrl
// Self-checking bench for lfsr_inv_ctrl. The golden constant sequence is
// built by running the forward encryption LFSR from 8'h36 until 8'h87 and
// reversing the trace. Three instances: default parameters, START_RC=8'h1B,
// and START_RC=8'h00 with MAX_STEPS=4 for the watchdog.
// ---------------------------------------------------------------------------
module tb_lfsr_inv_ctrl;

    localparam logic [7:0] TB_START = 8'h87;
    localparam logic [7:0] TB_END   = 8'h36;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic       rst_m, start_m, abort_m, rdy_m;
    logic [7:0] rc_m, cnt_m;
    logic       valid_m, first_m, last_m, busy_m, done_m, err_m;

    // START_RC = 8'h1B instance
    logic       start_b, rdy_b;
    logic [7:0] rc_b, cnt_b;
    logic       valid_b, first_b, last_b, busy_b, done_b, err_b;

    // watchdog instance
    logic       start_w, rdy_w;
    logic [7:0] rc_w, cnt_w;
    logic       valid_w, first_w, last_w, busy_w, done_w, err_w;

    logic rst_a;

    lfsr_inv_ctrl dut (
        .clk(clk), .rst(rst_m), .start(start_m), .abort(abort_m), .rc_ready(rdy_m),
        .rc(rc_m), .rc_valid(valid_m), .first_round(first_m), .last_round(last_m),
        .round_cnt(cnt_m), .busy(busy_m), .done(done_m), .err(err_m)
    );

    lfsr_inv_ctrl #(.START_RC(8'h1B)) dut_b (
        .clk(clk), .rst(rst_a), .start(start_b), .abort(1'b0), .rc_ready(rdy_b),
        .rc(rc_b), .rc_valid(valid_b), .first_round(first_b), .last_round(last_b),
        .round_cnt(cnt_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    lfsr_inv_ctrl #(.START_RC(8'h00), .MAX_STEPS(4)) dut_w (
        .clk(clk), .rst(rst_a), .start(start_w), .abort(1'b0), .rc_ready(rdy_w),
        .rc(rc_w), .rc_valid(valid_w), .first_round(first_w), .last_round(last_w),
        .round_cnt(cnt_w), .busy(busy_w), .done(done_w), .err(err_w)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] trace[$];
    logic [7:0] dec_seq[$];
    logic [7:0] exp_q[$];
    int         fwd_steps;

    typedef struct {
        logic       start;
        logic       abort;
        logic       rdy;
        logic [7:0] rc;
        logic       valid;
        logic       first;
        logic       last;
        logic       chk_cnt;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [7:0] fwdStep(input logic [7:0] r);
        return {r[0] ^ r[1] ^ r[5] ^ r[6], r[7:1]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic applyStimulus(input logic st, input logic ab, input logic rdy);
        start_m = st;
        abort_m = ab;
        rdy_m   = rdy;
        tick();
    endtask

    task automatic checkIdle(input string name);
        checkOutput({name, "_rc"}, rc_m, TB_START);
        checkOutput({name, "_busy"}, busy_m, 1'b0);
        checkOutput({name, "_valid"}, valid_m, 1'b0);
        checkOutput({name, "_done"}, done_m, 1'b0);
        checkOutput({name, "_err"}, err_m, 1'b0);
    endtask

    // start the main instance and take n accepted steps
    task automatic runSteps(input int n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("steps_rc", rc_m, dec_seq[n]);
        checkOutput("steps_cnt", cnt_m, n);
    endtask

    initial begin
        logic [7:0] r;
        logic [7:0] e;
        int   idx;
        bit   done_seen;
        bit   err_seen;
        bit   done_ever;
        int   accepts;
        logic rdy;

        // golden sequence from the forward LFSR
        r = TB_END;
        trace.push_back(r);
        for (int k = 0; k < 255 && r != TB_START; k++) begin
            r = fwdStep(r);
            trace.push_back(r);
        end
        for (int k = trace.size() - 1; k >= 0; k--) dec_seq.push_back(trace[k]);
        fwd_steps = trace.size() - 1;

        //            start abort rdy  rc     valid first last chk  cnt
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h87, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h87, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 8'h87, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0};
        vecs[5] = '{1'b0, 1'b0, 1'b1, 8'h0E, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 8'h87, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h87, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};

        rst_m = 1'b1; rst_a = 1'b1;
        start_m = 1'b0; abort_m = 1'b0; rdy_m = 1'b0;
        start_b = 1'b0; rdy_b = 1'b0; start_w = 1'b0; rdy_w = 1'b0;
        tick();
        tick();
        rst_m = 1'b0; rst_a = 1'b0;

        // reset state and idle hold
        checkIdle("reset");
        checkOutput("reset_cnt", cnt_m, 0);
        checkOutput("reset_first", first_m, 1'b0);
        checkOutput("reset_last", last_m, 1'b0);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0);
            checkOutput("idle_rc", rc_m, TB_START);
            checkOutput("idle_busy", busy_m, 1'b0);
        end

        // table vectors
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].start, vecs[i].abort, vecs[i].rdy);
            checkOutput($sformatf("vec%0d_rc", i), rc_m, vecs[i].rc);
            checkOutput($sformatf("vec%0d_valid", i), valid_m, vecs[i].valid);
            checkOutput($sformatf("vec%0d_busy", i), busy_m, vecs[i].valid);
            checkOutput($sformatf("vec%0d_first", i), first_m, vecs[i].first);
            checkOutput($sformatf("vec%0d_last", i), last_m, vecs[i].last);
            checkOutput($sformatf("vec%0d_done", i), done_m, 1'b0);
            if (vecs[i].chk_cnt)
                checkOutput($sformatf("vec%0d_cnt", i), cnt_m, vecs[i].cnt);
        end

        // full run with rc_ready held high
        applyStimulus(1'b1, 1'b0, 1'b0);
        idx = 0;
        exp_q.push_back(dec_seq[0]);
        done_seen = 0;
        for (int cyc = 0; cyc < 64 && !done_seen; cyc++) begin
            e = exp_q.pop_front();
            checkOutput("full_rc", rc_m, e);
            checkOutput("full_valid", valid_m, 1'b1);
            checkOutput("full_first", first_m, idx == 0);
            checkOutput("full_last", last_m, (e == TB_END) || (e == 8'h1B));
            checkOutput("full_done_early", done_m, 1'b0);
            if (idx == dec_seq.size() - 1) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                checkOutput("full_done", done_m, 1'b1);
                checkOutput("full_cnt", cnt_m, fwd_steps);
                checkOutput("full_done_valid", valid_m, 1'b0);
                checkOutput("full_done_err", err_m, 1'b0);
                done_seen = 1;
            end else begin
                idx++;
                exp_q.push_back(dec_seq[idx]);
                applyStimulus(1'b0, 1'b0, 1'b1);
            end
        end
        checkOutput("full_finished", done_seen, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkIdle("after_done");

        // random backpressure
        exp_q.delete();
        applyStimulus(1'b1, 1'b0, 1'b0);
        idx = 0;
        exp_q.push_back(dec_seq[0]);
        done_seen = 0;
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            e = exp_q.pop_front();
            checkOutput("bp_rc", rc_m, e);
            checkOutput("bp_valid", valid_m, 1'b1);
            rdy = 1'($urandom_range(0, 1));
            if (rdy && idx == dec_seq.size() - 1) begin
                applyStimulus(1'b0, 1'b0, 1'b1);
                checkOutput("bp_done", done_m, 1'b1);
                checkOutput("bp_cnt", cnt_m, fwd_steps);
                done_seen = 1;
            end else begin
                if (rdy) idx++;
                exp_q.push_back(dec_seq[idx]);
                applyStimulus(1'b0, 1'b0, rdy);
            end
        end
        checkOutput("bp_finished", done_seen, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // abort at step 3
        runSteps(3);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkIdle("abort");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1);
            checkOutput("abort_no_done", done_m, 1'b0);
            checkOutput("abort_busy", busy_m, 1'b0);
        end

        // reset at step 5
        runSteps(5);
        rst_m = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        rst_m = 1'b0;
        checkIdle("rst_mid");
        checkOutput("rst_mid_cnt", cnt_m, 0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("rst_mid_no_done", done_m, 1'b0);

        // start during RUN is ignored
        runSteps(2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("restart_rc", rc_m, dec_seq[2]);
        checkOutput("restart_cnt", cnt_m, 2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("restart_step", rc_m, dec_seq[3]);
        applyStimulus(1'b0, 1'b1, 1'b0);

        // START_RC = 8'h1B: one step lands on 8'h36
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        checkOutput("b_rc0", rc_b, 8'h1B);
        checkOutput("b_first0", first_b, 1'b1);
        checkOutput("b_last0", last_b, 1'b1);
        rdy_b = 1'b1;
        tick();
        checkOutput("b_rc1", rc_b, 8'h36);
        checkOutput("b_first1", first_b, 1'b0);
        checkOutput("b_last1", last_b, 1'b1);
        checkOutput("b_cnt1", cnt_b, 1);
        tick();
        checkOutput("b_done", done_b, 1'b1);
        rdy_b = 1'b0;
        tick();
        checkOutput("b_idle_rc", rc_b, 8'h1B);
        checkOutput("b_idle_busy", busy_b, 1'b0);

        // watchdog on the fixed point 8'h00
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        rdy_w = 1'b1;
        accepts = 0;
        err_seen = 0;
        done_ever = 0;
        for (int cyc = 0; cyc < 20 && !err_seen; cyc++) begin
            if (busy_w) begin
                checkOutput("wd_rc", rc_w, 8'h00);
                accepts++;
            end
            tick();
            if (done_w) done_ever = 1;
            if (err_w) err_seen = 1;
        end
        checkOutput("wd_err_seen", err_seen, 1'b1);
        checkOutput("wd_accepts", accepts, 4);
        checkOutput("wd_busy", busy_w, 1'b0);
        checkOutput("wd_done", done_w, 1'b0);
        rdy_w = 1'b0;
        tick();
        checkOutput("wd_err_pulse", err_w, 1'b0);
        checkOutput("wd_no_done", done_ever, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_lfsr_inv_ctrl

// File: doc/lfsr_inv_ctrl.md
Name: lfsr_inv_ctrl

Overview:
Decryption-side round-constant controller for the uBlock core. It is the inverse counterpart of the encryption round-constant LFSR. It loads the final encryption constant and steps the 8-bit LFSR backwards, one step per round accepted by the datapath, until it reaches the first-round constant. It flags the first and last decryption rounds and emits a done pulse. It sits between the decryption top-level FSM and the round datapath.

Parameters:
START_RC, 8'h87, constant presented in decryption round 0 (= last encryption constant)
END_RC, 8'h36, constant of the final decryption round (= first encryption constant)
MAX_STEPS, 255, watchdog: maximum inverse steps before error
CNT_W, 8, width of round counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a decryption run; honoured only in IDLE
abort  in  1  synchronous return to IDLE from any state
rc_ready  in  1  datapath consumed current constant; advance
rc  out  8  current round constant
rc_valid  out  1  rc is valid for the datapath
first_round  out  1  rc is the first decryption constant (rc==START_RC, in RUN)
last_round  out  1  rc is the final decryption constant (rc==END_RC or rc==8'h1B, in RUN)
round_cnt  out  CNT_W  number of steps taken in current run
busy  out  1  high in RUN
done  out  1  one-cycle pulse on normal completion
err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Inverse step, n = current rc: next = {n[6:0], n[7]^n[0]^n[4]^n[5]}. This exactly undoes forward step {r0^r1^r5^r6, r[7:1]}.
- Reset (rst=1 at edge): state IDLE; rc=START_RC; round_cnt=0; rc_valid=busy=done=err=first_round=last_round=0. Applies mid-run; the run is discarded.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> RUN, rc<=START_RC, round_cnt<=0. Other inputs are ignored.
- RUN: rc_valid=1, busy=1. Combinational flags valid only in RUN.
  - rc_ready=0: hold all state.
  - rc_ready=1 and rc==END_RC -> DONE; rc and round_cnt hold.
  - rc_ready=1 and round_cnt==MAX_STEPS-1 (and rc!=END_RC) -> IDLE; err=1 for one cycle; rc<=START_RC.
  - Otherwise: rc<=inverse step of rc; round_cnt<=round_cnt+1.
- DONE: lasts exactly one cycle; done=1; rc_valid=0; then -> IDLE with rc<=START_RC.
- done and err are registered pulses, asserted in the cycle after the triggering handshake. They are never both high.
- Latency: rc_valid rises the cycle after start. Each accepted rc_ready yields the next constant on the following cycle, giving one round per cycle at full throughput.
- start while RUN or DONE: ignored (no restart).
- abort: highest priority after rst. Any state -> IDLE next cycle, rc<=START_RC, no done/err pulse. abort and start together in IDLE: abort wins, stays IDLE.
- round_cnt does not wrap; the watchdog fires before overflow (MAX_STEPS <= 2^CNT_W - 1).
- No combinational path from inputs to rc. rc_valid, busy, done and err decode from registered state only.

Decomposition:
- Shared package ublock_pkg: RC_LAST_ENC=8'h87, RC_FIRST_ENC=8'h36, RC_SECOND_ENC=8'h1B, and the state enum {IDLE, RUN, DONE}. The encryption LFSR uses the same constants.
- One sub-module is natural: lfsr_inv_step, a pure combinational 8-bit inverse step function. It is reused by the verification model and any future key-schedule inversion.

Test Plan:
- Reset then idle: rst=1 one cycle -> rc=8'h87, busy=0, rc_valid=0, done=0, err=0. Hold start=0 for 10 cycles -> outputs unchanged.
- Single steps: start, rc_ready=1 one cycle -> rc goes 8'h87 -> 8'h0E. Load 8'h1B via parameter START_RC and step -> 8'h36, last_round=1.
- Full run with rc_ready held high: sequence equals the reversed forward-LFSR trace from 8'h36 to 8'h87. done pulses once, round_cnt equals forward step count, first_round high only on the first constant.
- Backpressure: toggle rc_ready randomly -> rc changes only on cycles after rc_ready=1, with no skipped or repeated constants versus the golden model.
- Watchdog: START_RC=8'h00 (fixed point of the step) with MAX_STEPS=4 -> err pulses after 4 accepts, state returns to IDLE, and done never asserts.
- Disruption: abort at step 3 -> IDLE next cycle, rc=8'h87, no done. rst at step 5 -> same result. start during RUN -> ignored and the sequence continues.
